// File: rtl/seg_decoder.sv
// seg_decoder: synchronise, debounce and decode active-low 7-segment lines.
// Define SEG_DECODER_SEQ_CHECK_EN to build the up-count sequence checker.
module seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       clr,
    output logic [2:0] value,
    output logic       valid,
    output logic       blank,
    output logic       bad_pat,
    output logic       seq_err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam logic [6:0] BLANK  = 7'b1111111;

    logic [6:0] r_s1;
    logic [6:0] r_s2;
    logic [6:0] r_cand;
    logic [6:0] r_last;
    logic [7:0] r_cnt;

    logic       w_acc;
    logic [6:0] w_pat;
    logic       w_legal;
    logic       w_blank;
    logic [2:0] w_digit;
    logic       w_bad;
    logic       w_seq_err;
    logic       w_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= BLANK;
            r_s2   <= BLANK;
            r_cand <= BLANK;
            r_cnt  <= 8'd0;
        end else begin
            r_s1 <= {a, b, c, d, e, f, g};
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= 8'd1;
            end else if (r_cnt < STABLE) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Acceptance fires on the edge where the count reaches STABLE.
    always_comb begin
        w_acc = 1'b0;
        w_pat = r_cand;
        if (r_s2 != r_cand) begin
            w_pat = r_s2;
            w_acc = (STABLE == 8'd1) && (r_s2 != r_last);
        end else if (r_cnt < STABLE) begin
            w_acc = ((r_cnt + 8'd1) == STABLE) && (r_cand != r_last);
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_blank = 1'b0;
        w_digit = 3'd0;
        case (w_pat)
            7'b0000001: w_digit = 3'd0;
            7'b1001111: w_digit = 3'd1;
            7'b0010010: w_digit = 3'd2;
            7'b0000110: w_digit = 3'd3;
            7'b1001100: w_digit = 3'd4;
            7'b0100100: w_digit = 3'd5;
            7'b0100000: w_digit = 3'd6;
            7'b0001111: w_digit = 3'd7;
            7'b1111111: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_bad = w_acc && !w_legal && !w_blank;

`ifdef SEG_DECODER_SEQ_CHECK_EN
    logic       r_ref_ok;
    logic [2:0] r_prev;

    assign w_seq_err = w_acc && w_legal && r_ref_ok &&
                       (w_digit != (r_prev + 3'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_ok <= 1'b0;
            r_prev   <= 3'd0;
        end else begin
            if (w_acc) begin
                if (w_legal) begin
                    r_ref_ok <= 1'b1;
                    r_prev   <= w_digit;
                end else begin
                    r_ref_ok <= 1'b0;
                end
            end
            if (clr) begin
                r_ref_ok <= 1'b0;
            end
        end
    end
`else
    assign w_seq_err = 1'b0;
`endif

    assign w_inc = w_bad || w_seq_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last  <= BLANK;
            value   <= 3'd0;
            valid   <= 1'b0;
            blank   <= 1'b1;
            bad_pat <= 1'b0;
            seq_err <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            valid   <= w_acc && w_legal;
            bad_pat <= w_bad;
            seq_err <= w_seq_err;
            if (w_acc) begin
                r_last <= w_pat;
            end
            if (w_acc && w_legal) begin
                value <= w_digit;
                blank <= 1'b0;
            end
            if (w_acc && w_blank) begin
                blank <= 1'b1;
            end
            if (clr) begin
                err_cnt <= 8'd0;
            end else if (w_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
